// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared types, constants and saturating adder for the DSP MAC array
package dsp_pkg;

    localparam int DEF_VALUE_WIDTH = 17;
    localparam int DEF_MUL_STAGES  = 2;
    localparam int DEF_ACC_WIDTH   = 2 * DEF_VALUE_WIDTH + 8;
    localparam int LATENCY         = DEF_MUL_STAGES + 1;

    // Working width of sat_add; any ACC_WIDTH up to ACC_MAX-1 is handled.
    localparam int ACC_MAX = 64;

    typedef logic signed [DEF_VALUE_WIDTH-1:0]   operand_t;
    typedef logic signed [2*DEF_VALUE_WIDTH-1:0] product_t;
    typedef logic signed [DEF_ACC_WIDTH-1:0]     acc_t;
    typedef logic signed [ACC_MAX-1:0]           wide_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_ACC = 1'b1
    } mac_mode_e;

    typedef struct packed {
        wide_t sum;
        logic  ovf;
    } sat_res_t;

    // Adds two values that already lie in the signed range of 'width' bits and
    // returns the result folded back into that range: clamped when saturate is
    // set, otherwise wrapped. ovf reports that the true sum left the range.
    function automatic sat_res_t sat_add(input wide_t a, input wide_t b,
                                         input int width, input logic saturate);
        logic signed [ACC_MAX:0] s;
        logic signed [ACC_MAX:0] one;
        logic signed [ACC_MAX:0] hi;
        logic signed [ACC_MAX:0] lo;
        logic signed [ACC_MAX:0] w;
        sat_res_t                r;
        one    = '0;
        one[0] = 1'b1;
        s      = {a[ACC_MAX-1], a} + {b[ACC_MAX-1], b};
        hi     = (one <<< (width - 1)) - one;
        lo     = ~hi;
        r.ovf  = (s > hi) || (s < lo);
        if (!r.ovf) begin
            w = s;
        end else if (saturate) begin
            w = s[ACC_MAX] ? lo : hi;
        end else begin
            w = (s <<< (ACC_MAX + 1 - width)) >>> (ACC_MAX + 1 - width);
        end
        r.sum = wide_t'(w);
        return r;
    endfunction

endpackage

// File: rtl/dsp_mac_lane.sv
// rtl/dsp_mac_lane.sv - one signed multiply/accumulate lane with sticky overflow
module dsp_mac_lane
    import dsp_pkg::*;
#(
    parameter int VALUE_WIDTH = 17,
    parameter int MUL_STAGES  = 2,
    parameter int ACC_WIDTH   = 42,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [VALUE_WIDTH-1:0] a,
    input  logic signed [VALUE_WIDTH-1:0] b,
    input  logic                          acc_valid,
    input  logic                          acc_first,
    input  logic                          acc_last,
    input  mac_mode_e                     acc_mode,
    output logic signed [ACC_WIDTH-1:0]   out,
    output logic                          ovf
);

    localparam int PW = 2 * VALUE_WIDTH;

    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        prod_q [MUL_STAGES];
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        sticky_q;
    logic                        frame_ovf;
    wide_t                       acc_base;
    wide_t                       prod_wide;
    sat_res_t                    res;

    assign prod = PW'(a) * PW'(b);

    // Product pipeline; stage validity is tracked by the shared control.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else if (en) begin
            prod_q[0] <= prod;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    // Accumulate step: the first beat of a frame ignores whatever acc_q holds.
    always_comb begin
        prod_ext  = ACC_WIDTH'(prod_q[MUL_STAGES-1]);
        prod_wide = wide_t'(prod_q[MUL_STAGES-1]);
        acc_base  = acc_first ? '0 : wide_t'(acc_q);
        res       = sat_add(acc_base, prod_wide, ACC_WIDTH, SATURATE);
        sum       = ACC_WIDTH'(res.sum);
        frame_ovf = (sticky_q && !acc_first) || res.ovf;
    end

    // Result/accumulator register; a frame's last beat publishes and clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
            out      <= '0;
            ovf      <= 1'b0;
        end else if (en && acc_valid) begin
            if (acc_mode == MODE_MUL) begin
                out <= prod_ext;
                ovf <= 1'b0;
            end else if (acc_last) begin
                out      <= sum;
                ovf      <= frame_ovf;
                acc_q    <= '0;
                sticky_q <= 1'b0;
            end else begin
                acc_q    <= sum;
                sticky_q <= frame_ovf;
            end
        end
    end

endmodule

// File: rtl/dsp_mac_array.sv
// rtl/dsp_mac_array.sv - NUM_LANES parallel signed MAC lanes behind one valid/ready handshake
module dsp_mac_array
    import dsp_pkg::*;
#(
    parameter int VALUE_WIDTH = 17,
    parameter int NUM_LANES   = 2,
    parameter int MUL_STAGES  = 2,
    parameter int ACC_WIDTH   = 2 * VALUE_WIDTH + 8,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic                             i_mode,
    input  logic                             i_last,
    input  logic [NUM_LANES*VALUE_WIDTH-1:0] i_mul_a,
    input  logic [NUM_LANES*VALUE_WIDTH-1:0] i_mul_b,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [NUM_LANES*ACC_WIDTH-1:0]   o_out,
    output logic [NUM_LANES-1:0]             o_ovf
);

    localparam int L = MUL_STAGES - 1;

    logic                  stall;
    logic                  en;
    logic                  accept;
    logic                  in_frame_q;
    mac_mode_e             frame_mode_q;
    mac_mode_e             beat_mode;
    logic                  beat_first;
    logic [MUL_STAGES-1:0] v_q;
    logic [MUL_STAGES-1:0] first_q;
    logic [MUL_STAGES-1:0] last_q;
    mac_mode_e             mode_q [MUL_STAGES];

    assign stall   = o_valid && !i_ready;
    assign en      = !stall;
    assign o_ready = en;
    assign accept  = i_valid && en;

    // Mode for the current beat: taken from i_mode only when no frame is open.
    always_comb begin
        beat_first = !in_frame_q;
        beat_mode  = in_frame_q ? frame_mode_q : mac_mode_e'(i_mode);
    end

    // Frame-mode latch; only a multi-beat accumulate frame stays open.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            in_frame_q   <= 1'b0;
            frame_mode_q <= MODE_MUL;
        end else if (accept) begin
            if (in_frame_q) begin
                if (i_last) begin
                    in_frame_q <= 1'b0;
                end
            end else begin
                frame_mode_q <= beat_mode;
                if (beat_mode == MODE_ACC && !i_last) begin
                    in_frame_q <= 1'b1;
                end
            end
        end
    end

    // Beat control travels alongside the lane product pipelines.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_q     <= '0;
            first_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                mode_q[i] <= MODE_MUL;
            end
        end else if (en) begin
            v_q[0]     <= i_valid;
            first_q[0] <= beat_first;
            last_q[0]  <= i_last;
            mode_q[0]  <= beat_mode;
            for (int i = 1; i < MUL_STAGES; i++) begin
                v_q[i]     <= v_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
                mode_q[i]  <= mode_q[i-1];
            end
        end
    end

    // A result leaves for every multiply beat and for each accumulate frame's last beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
        end else if (en) begin
            o_valid <= v_q[L] && (mode_q[L] == MODE_MUL || last_q[L]);
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dsp_mac_lane #(
            .VALUE_WIDTH (VALUE_WIDTH),
            .MUL_STAGES  (MUL_STAGES),
            .ACC_WIDTH   (ACC_WIDTH),
            .SATURATE    (SATURATE)
        ) u_lane (
            .clk       (i_clk),
            .rst       (i_rst),
            .en        (en),
            .a         (i_mul_a[g*VALUE_WIDTH +: VALUE_WIDTH]),
            .b         (i_mul_b[g*VALUE_WIDTH +: VALUE_WIDTH]),
            .acc_valid (v_q[L]),
            .acc_first (first_q[L]),
            .acc_last  (last_q[L]),
            .acc_mode  (mode_q[L]),
            .out       (o_out[g*ACC_WIDTH +: ACC_WIDTH]),
            .ovf       (o_ovf[g])
        );
    end

endmodule

// File: tb/tb_dsp_mac_array.sv
// tb/tb_dsp_mac_array.sv - scoreboard bench for dsp_mac_array
module tb_dsp_mac_array;
    import dsp_pkg::*;

    localparam int VW  = 17;
    localparam int NL  = 2;
    localparam int AW  = 2 * VW + 8;
    localparam int AWS = 34;

    typedef struct packed {
        logic [5:0][63:0] v;
        logic [5:0]       ov;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              i_valid;
    logic              i_mode;
    logic              i_last;
    logic              i_ready;
    logic [NL*VW-1:0]  i_mul_a;
    logic [NL*VW-1:0]  i_mul_b;
    logic              o_ready, s_ready, w_ready;
    logic              o_valid, s_valid, w_valid;
    logic [NL*AW-1:0]  o_out;
    logic [NL*AWS-1:0] s_out, w_out;
    logic [NL-1:0]     o_ovf, s_ovf, w_ovf;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic              m_in_frame;
    logic              m_mode;
    logic signed [63:0] m_acc [3][2];
    logic              m_st  [3][2];

    dsp_mac_array u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_mode(i_mode), .i_last(i_last), .i_mul_a(i_mul_a), .i_mul_b(i_mul_b),
        .o_valid(o_valid), .i_ready(i_ready), .o_out(o_out), .o_ovf(o_ovf)
    );

    dsp_mac_array #(.ACC_WIDTH(AWS), .SATURATE(1'b1)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(s_ready),
        .i_mode(i_mode), .i_last(i_last), .i_mul_a(i_mul_a), .i_mul_b(i_mul_b),
        .o_valid(s_valid), .i_ready(i_ready), .o_out(s_out), .o_ovf(s_ovf)
    );

    dsp_mac_array #(.ACC_WIDTH(AWS), .SATURATE(1'b0)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(w_ready),
        .i_mode(i_mode), .i_last(i_last), .i_mul_a(i_mul_a), .i_mul_b(i_mul_b),
        .o_valid(w_valid), .i_ready(i_ready), .o_out(w_out), .o_ovf(w_ovf)
    );

    initial begin
        #400000;
        $display("FAIL watchdog sim_time=%0t limit=400000", $time);
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference accumulate for config c: 0 = 42-bit clamp, 1 = 34-bit clamp, 2 = 34-bit wrap.
    function automatic void madd(input int c, input int l, input logic signed [63:0] p);
        int                 w;
        logic signed [63:0] s, hi, lo, span;
        w    = (c == 0) ? AW : AWS;
        hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo   = -hi - 64'sd1;
        span = 64'sd1 <<< w;
        s    = m_acc[c][l] + p;
        if (s > hi || s < lo) begin
            m_st[c][l] = 1'b1;
            if (c != 2) begin
                s = (s > hi) ? hi : lo;
            end else begin
                while (s > hi) s = s - span;
                while (s < lo) s = s + span;
            end
        end
        m_acc[c][l] = s;
    endfunction

    task automatic model_accept(input logic signed [VW-1:0] a0, a1, b0, b1,
                                input logic mode, input logic last);
        logic signed [63:0] p [2];
        logic               first;
        logic               eff;
        exp_t               e;
        p[0]  = 64'(a0) * 64'(b0);
        p[1]  = 64'(a1) * 64'(b1);
        first = !m_in_frame;
        eff   = m_in_frame ? m_mode : mode;
        if (first) m_mode = mode;
        e = '0;
        if (!eff) begin
            for (int c = 0; c < 3; c++)
                for (int l = 0; l < 2; l++)
                    e.v[c*2+l] = p[l];
            sb.push_back(e);
        end else begin
            for (int c = 0; c < 3; c++) begin
                for (int l = 0; l < 2; l++) begin
                    if (first) begin
                        m_acc[c][l] = 64'sd0;
                        m_st[c][l]  = 1'b0;
                    end
                    madd(c, l, p[l]);
                    e.v[c*2+l]  = m_acc[c][l];
                    e.ov[c*2+l] = m_st[c][l];
                end
            end
            if (last) begin
                sb.push_back(e);
                m_in_frame = 1'b0;
            end else begin
                m_in_frame = 1'b1;
            end
        end
    endtask

    // Presents one beat and holds it until the DUT takes it.
    task automatic send(input int a0, a1, b0, b1, input logic mode, input logic last);
        logic signed [VW-1:0] x0, x1, y0, y1;
        logic                 took;
        x0 = VW'(a0); x1 = VW'(a1); y0 = VW'(b0); y1 = VW'(b1);
        i_mul_a = {x1, x0};
        i_mul_b = {y1, y0};
        i_mode  = mode;
        i_last  = last;
        i_valid = 1'b1;
        took    = 1'b0;
        for (int k = 0; k < 100 && !took; k++) begin
            @(negedge clk);
            took = o_ready;
            cycle();
        end
        if (!took) begin
            total++; bad++;
            $display("FAIL send_timeout got=no_accept want=accept");
        end else begin
            model_accept(x0, x1, y0, y1, mode, last);
        end
        i_valid = 1'b0;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result got=%h want=none", o_out);
                end else begin
                    mon_e = sb.pop_front();
                    total++;
                    if (s_valid !== 1'b1 || w_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL aux_valid got=%b%b want=11", s_valid, w_valid);
                    end
                    for (int l = 0; l < NL; l++) begin
                        total++;
                        if (o_out[l*AW +: AW] !== mon_e.v[l][AW-1:0] || o_ovf[l] !== mon_e.ov[l]) begin
                            bad++;
                            $display("FAIL res_main lane%0d got=%0d/%b want=%0d/%b", l,
                                     $signed(o_out[l*AW +: AW]), o_ovf[l],
                                     $signed(mon_e.v[l][AW-1:0]), mon_e.ov[l]);
                        end
                        total++;
                        if (s_out[l*AWS +: AWS] !== mon_e.v[2+l][AWS-1:0] || s_ovf[l] !== mon_e.ov[2+l]) begin
                            bad++;
                            $display("FAIL res_sat34 lane%0d got=%0d/%b want=%0d/%b", l,
                                     $signed(s_out[l*AWS +: AWS]), s_ovf[l],
                                     $signed(mon_e.v[2+l][AWS-1:0]), mon_e.ov[2+l]);
                        end
                        total++;
                        if (w_out[l*AWS +: AWS] !== mon_e.v[4+l][AWS-1:0] || w_ovf[l] !== mon_e.ov[4+l]) begin
                            bad++;
                            $display("FAIL res_wrap34 lane%0d got=%0d/%b want=%0d/%b", l,
                                     $signed(w_out[l*AWS +: AWS]), w_ovf[l],
                                     $signed(mon_e.v[4+l][AWS-1:0]), mon_e.ov[4+l]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            cycle();
            k++;
        end
        repeat (4) cycle();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        total++;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL %s_valid got=%b want=0", tag, o_valid); end
        total++;
        if (o_out !== '0) begin bad++; $display("FAIL %s_out got=%h want=0", tag, o_out); end
        total++;
        if (o_ovf !== '0) begin bad++; $display("FAIL %s_ovf got=%b want=0", tag, o_ovf); end
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b want=1", tag, o_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_last = 1'b0; i_ready = 1'b1;
        i_mul_a = '0; i_mul_b = '0;
        m_in_frame = 1'b0; m_mode = 1'b0;
        repeat (3) cycle();
        check_reset_values("reset");
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_mul();
        send(3, -2, 4, 5, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            total++;
            if (o_valid !== (n == 2)) begin
                bad++;
                $display("FAIL mul_latency cycle%0d got=%b want=%b", n + 1, o_valid, n == 2);
            end
            cycle();
        end
        send(-65536, -65536, -65536, 65535, 1'b0, 1'b0);
        send(7, 100, -9, 1, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_acc_back_to_back();
        for (int i = 0; i < 4; i++) send(1000, -1000, 1000, 1000, 1'b1, i == 3);
        send(5, 6, 7, -8, 1'b1, 1'b0);
        send(-3, 2, 11, 2, 1'b1, 1'b0);
        send(4, 4, 4, 4, 1'b1, 1'b1);
        send(12, -12, 3, 3, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 8; i++) send(65535, -65536, 65535, 65535, 1'b1, i == 7);
        send(2, 3, 4, 5, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_stall();
        fork
            begin
                for (int i = 1; i <= 6; i++) send(i, -i, i + 1, 3, 1'b0, 1'b0);
            end
            begin
                repeat (4) cycle();
                i_ready = 1'b0;
                for (int n = 0; n < 5; n++) begin
                    @(negedge clk);
                    total++;
                    if (o_valid !== 1'b1 || o_ready !== 1'b0 || s_ready !== 1'b0 || w_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_ready cycle%0d got=v%b r%b%b%b want=v1 r000",
                                 n, o_valid, o_ready, s_ready, w_ready);
                    end
                    cycle();
                end
                i_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_mode_toggle();
        send(3, 4, 5, 6, 1'b1, 1'b0);
        send(2, 2, 2, -2, 1'b0, 1'b0);
        send(10, 1, 10, 1, 1'b0, 1'b1);
        send(9, 8, 7, 6, 1'b0, 1'b0);
        send(-4, 4, 5, 5, 1'b1, 1'b1);
        send(6, 6, 6, 6, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_mid_reset();
        send(50, 60, 70, 80, 1'b1, 1'b0);
        send(51, 61, 71, 81, 1'b1, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        m_in_frame = 1'b0;
        check_reset_values("midrst");
        cycle();
        send(2, 3, 4, 5, 1'b1, 1'b0);
        send(1, 1, 1, 1, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_random();
        fork
            begin
                for (int i = 0; i < 24; i++)
                    send($urandom_range(0, 131071), $urandom_range(0, 131071),
                         $urandom_range(0, 131071), $urandom_range(0, 131071),
                         1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) || (i == 23));
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    i_ready = ($urandom_range(0, 3) != 0);
                    cycle();
                end
                i_ready = 1'b1;
            end
        join
        i_ready = 1'b1;
        drain();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_mul();
        test_acc_back_to_back();
        test_saturate();
        test_stall();
        test_mode_toggle();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
